// File: rtl/move_requester.sv
// move_requester: turns a source and a destination cursor select into one request to the
// move validator, then reports commit/reject. Define MOVE_REQ_TIMEOUT_EN to build the WAIT timeout.
module move_requester #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sel_valid,
    input  logic [2:0]             sel_x,
    input  logic [2:0]             sel_y,
    input  logic [7:0][7:0][3:0]   board_in,
    output logic [2:0]             old_x,
    output logic [2:0]             old_y,
    output logic [2:0]             new_x,
    output logic [2:0]             new_y,
    output logic [3:0]             piece_type,
    output logic                   valid_input,
    input  logic                   valid_move,
    input  logic                   valid_output,
    output logic                   commit,
    output logic                   reject,
    output logic                   busy,
    output logic                   src_selected,
    output logic                   side_to_move
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SRC_HELD,
        S_REQ,
        S_WAIT
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0] sel_piece;
    logic       sel_own;
    logic       sel_same;
    logic       verdict;
    logic       timeout_hit;

    assign sel_piece = board_in[sel_y][sel_x];
    assign sel_same  = (sel_x == old_x) && (sel_y == old_y);
    assign verdict   = (state == S_WAIT) && valid_output;

    // A square is selectable as a source only if it holds a piece of the side to move.
    always_comb begin
        if (side_to_move)
            sel_own = (sel_piece >= 4'd6) && (sel_piece <= 4'd11);
        else
            sel_own = (sel_piece <= 4'd5);
    end

`ifdef MOVE_REQ_TIMEOUT_EN
    localparam int            CW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] COUNT_END = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] wait_count;

    always_ff @(posedge clk) begin
        if (reset)
            wait_count <= '0;
        else if (state_next == S_REQ)
            wait_count <= '0;
        else if ((state == S_WAIT) && (wait_count != COUNT_MAX))
            wait_count <= wait_count + 1'b1;
    end

    // The last WAIT cycle without a verdict aborts; a verdict in that same cycle wins.
    assign timeout_hit = (state == S_WAIT) && !valid_output && (wait_count == COUNT_END);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (sel_valid && sel_own)
                    state_next = S_SRC_HELD;
            end
            S_SRC_HELD: begin
                if (sel_valid) begin
                    if (sel_same)
                        state_next = S_IDLE;
                    else if (!sel_own)
                        state_next = S_REQ;
                end
            end
            S_REQ: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (verdict || timeout_hit)
                    state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        valid_input  = (state == S_REQ);
        busy         = (state == S_REQ) || (state == S_WAIT);
        src_selected = (state == S_SRC_HELD);
    end

    // Request coordinates only move on a latch, so they stay put from REQ through the verdict.
    always_ff @(posedge clk) begin
        if (reset) begin
            old_x      <= 3'd0;
            old_y      <= 3'd0;
            new_x      <= 3'd0;
            new_y      <= 3'd0;
            piece_type <= 4'd15;
        end else if (sel_valid && sel_own &&
                     ((state == S_IDLE) || ((state == S_SRC_HELD) && !sel_same))) begin
            old_x      <= sel_x;
            old_y      <= sel_y;
            piece_type <= sel_piece;
        end else if (sel_valid && (state == S_SRC_HELD) && !sel_same) begin
            new_x <= sel_x;
            new_y <= sel_y;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            commit       <= 1'b0;
            reject       <= 1'b0;
            side_to_move <= 1'b0;
        end else begin
            commit <= verdict && valid_move;
            reject <= (verdict && !valid_move) || timeout_hit;
            if (verdict && valid_move)
                side_to_move <= ~side_to_move;
        end
    end

endmodule

// File: doc/move_requester.md
# move_requester

Initiator side of the move-validation handshake. Turns two cursor selections (source, then destination) into one move request to `board_validator`, holds the request stable until the verdict returns, then reports a commit or reject pulse to the game-play controller. It also owns the side-to-move register. Sits between the cursor/input logic and `board_validator` in `game_play`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: cycles spent in WAIT without a verdict before the request is aborted. Only used when the timeout feature is compiled in.

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `sel_valid`  in  1  one-cycle cursor-select pulse
- `sel_x`, `sel_y`  in  3 each  cursor square; sampled only when `sel_valid=1`
- `board_in`  in  4 [8][8]  current board. Piece codes: 0–5 white (rook, knight, bishop, queen, king, pawn); 6–11 black (same order); 12–15 empty
- `old_x`, `old_y`, `new_x`, `new_y`  out  3 each  request coordinates to the validator
- `piece_type`  out  4  code of the piece on the source square
- `valid_input`  out  1  one-cycle request strobe to the validator
- `valid_move`  in  1  validator verdict; meaningful only when `valid_output=1`
- `valid_output`  in  1  one-cycle verdict strobe from the validator
- `commit`  out  1  one-cycle pulse: move accepted; coordinate and `piece_type` outputs are valid in the same cycle
- `reject`  out  1  one-cycle pulse: move refused or timed out
- `busy`  out  1  high in REQ and WAIT
- `src_selected`  out  1  high in SRC_HELD (drives source highlight)
- `side_to_move`  out  1  0 = white, 1 = black

## Operation
The FSM has four states: IDLE, SRC_HELD, REQ, WAIT.

- **IDLE**
  - On `sel_valid`, read `board_in[sel_y][sel_x]`.
  - If it holds a piece of `side_to_move` (0–5 for white, 6–11 for black): latch `old_x`/`old_y`/`piece_type` and go to SRC_HELD.
  - Otherwise ignore the select: no pulse, no state change.
- **SRC_HELD**, on `sel_valid`:
  - Same square as the source: deselect and go to IDLE. No pulse.
  - Square holds another piece of the side to move: re-latch it as the new source and stay in SRC_HELD.
  - Anything else: latch `new_x`/`new_y` and go to REQ.
- **REQ**
  - Lasts exactly one cycle with `valid_input=1`, then go to WAIT.
- **WAIT**
  - On `valid_output` with `valid_move=1`: pulse `commit`, toggle `side_to_move`, go to IDLE.
  - On `valid_output` with `valid_move=0`: pulse `reject` and go to IDLE. `side_to_move` is unchanged.
- **Stability:** `old_*`, `new_*` and `piece_type` are held from the REQ cycle through the `commit`/`reject` cycle. They change only on a later latch.
- **Ignored inputs:**
  - `sel_valid` is ignored in REQ and WAIT.
  - `valid_output` is ignored outside WAIT.
- **Widths:** coordinates are compared as full 3-bit values. The timeout counter width is `$clog2(TIMEOUT_CYCLES+1)`. The counter saturates and never wraps.

## Timing
- **Reset values** (one edge with `reset=1`, from any state):
  - State IDLE.
  - `valid_input`, `commit`, `reject`, `busy`, `src_selected` = 0.
  - `side_to_move` = 0.
  - `old_*`, `new_*` = 0; `piece_type` = 4'd15.
  - Timeout counter = 0.
  - Reset during WAIT drops the request; a later `valid_output` is ignored.
- **Source select:** `sel_valid` at cycle t → `src_selected=1` at t+1.
- **Destination select:** `sel_valid` at t2 → `valid_input=1` and `busy=1` during t2+1 only → WAIT from t2+2.
- **Verdict:** `valid_output` sampled high at cycle r → `commit` or `reject` registered high during r+1. FSM is in IDLE at r+1 and `busy=0`. `side_to_move` shows its new value at r+1.
- **Minimum round trip** with a 2-cycle validator: `valid_input` at t2+1, verdict at t2+3, `commit` at t2+4.
- **New selects:** the earliest `sel_valid` that is acted on after a verdict is at r+1.
- **Simultaneous events:** `sel_valid` and `valid_output` in the same WAIT cycle → the verdict is processed and the select is dropped.

## Configuration
- **`MOVE_REQ_TIMEOUT_EN` defined:**
  - The WAIT counter increments each WAIT cycle and clears on entering REQ.
  - When it reaches `TIMEOUT_CYCLES` with no `valid_output`: pulse `reject` next cycle, go to IDLE, leave `side_to_move` unchanged.
  - If `valid_output` arrives in the cycle the counter reaches `TIMEOUT_CYCLES`, the verdict wins.
- **Undefined:** no counter is built and WAIT waits indefinitely. The `TIMEOUT_CYCLES` parameter remains but is unused.

## Test plan
- **Legal white pawn move:** reset; white pawn (5) at (4,6); select (4,6), then (4,4); validator returns `valid_output=1`, `valid_move=1` two cycles after `valid_input`.
  → one `valid_input` pulse with old=(4,6), new=(4,4), piece_type=5; then `commit=1` for one cycle; `side_to_move`=1.
- **Rejected move:** same selections, validator returns `valid_move=0`.
  → `reject` pulse; `side_to_move` stays 0; `commit` never asserts.
- **Selection filtering:**
  - Select an empty square (code 15), then a black piece (code 11) while white is to move → no state change, no pulses.
  - Select white (4,6), then the same square → `src_selected` rises then falls, no `valid_input`.
  - Select white (4,6), then white (3,6) → source re-latched to (3,6).
- **Busy masking:** during WAIT, drive `sel_valid` at (0,0) and hold `valid_output=0` for 5 cycles.
  → outputs stay stable; the select has no effect after the verdict.
- **Timeout** (`MOVE_REQ_TIMEOUT_EN`, `TIMEOUT_CYCLES=16`): validator never responds.
  → `reject` pulses 16 cycles after WAIT entry; FSM back in IDLE.
  - Without the macro: `busy` stays high for 100+ cycles.
- **Reset mid-WAIT:** assert `reset` for one cycle in WAIT, then pulse `valid_output=1`, `valid_move=1`.
  → all outputs at reset values; no `commit`; `side_to_move`=0.
